// File: rtl/alu_op_pkg.sv
// ALU control encodings, RV32I opcode/funct7 constants and the issue payload type
// shared by the decode/issue stage and the execute-stage ALU.
package alu_op_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_OR    = 4'b0010;
   localparam logic [3:0] ALU_XOR   = 4'b0011;
   localparam logic [3:0] ALU_AND   = 4'b0100;
   localparam logic [3:0] ALU_SRL   = 4'b0101;
   localparam logic [3:0] ALU_SRA   = 4'b0110;
   localparam logic [3:0] ALU_SLL   = 4'b0111;
   localparam logic [3:0] ALU_SLTU  = 4'b1000;
   localparam logic [3:0] ALU_SLT   = 4'b1001;
   localparam logic [3:0] ALU_LUIB  = 4'b1010;
   localparam logic [3:0] ALU_SHL16 = 4'b1011;
   localparam logic [3:0] ALU_AUIPC = 4'b1100;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0] ctrl;
      logic       cmp_sel;
      logic [4:0] rd;
      logic       we;
      logic       illegal;
   } issue_ctl_t;

   // alt selects SUB for funct3 000 and SRA for funct3 101
   function automatic logic [3:0] f3_ctrl(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of OP/OP-IMM/LUI/AUIPC into ALU operands and issue controls.
// Illegal encodings produce zero operands, ADD control and no register write.
module alu_op_decode import alu_op_pkg::*; #(
   parameter int N = 32
) (
   input  logic [31:0]  instr_i,
   input  logic [N-1:0] pc_i,
   input  logic [N-1:0] rs1_i,
   input  logic [N-1:0] rs2_i,
   output logic [N-1:0] a_o,
   output logic [N-1:0] b_o,
   output issue_ctl_t   ctl_o
);

   logic [6:0]   opcode;
   logic [6:0]   funct7;
   logic [2:0]   funct3;
   logic [4:0]   rd;
   logic [N-1:0] imm_s;
   logic [N-1:0] shamt;
   logic [N-1:0] upper;
   logic         legal;
   logic         alt;
   logic [3:0]   ctrl;

   assign opcode = instr_i[6:0];
   assign rd     = instr_i[11:7];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign imm_s  = {{(N-12){instr_i[31]}}, instr_i[31:20]};
   assign shamt  = {{(N-5){1'b0}}, instr_i[24:20]};
   assign upper  = {{(N-20){1'b0}}, instr_i[31:12]};

   always_comb begin
      a_o   = '0;
      b_o   = '0;
      legal = 1'b1;
      alt   = 1'b0;
      ctrl  = ALU_ADD;
      ctl_o = '0;
      case (opcode)
         OPC_OP: begin
            a_o   = rs1_i;
            b_o   = rs2_i;
            alt   = (funct7 == F7_ALT);
            legal = (funct7 == F7_BASE) || (alt && (funct3 == 3'b000 || funct3 == 3'b101));
            ctrl  = f3_ctrl(funct3, alt);
         end
         OPC_OPIMM: begin
            a_o = rs1_i;
            b_o = imm_s;
            if (funct3 == 3'b001) begin
               b_o   = shamt;
               legal = (funct7 == F7_BASE);
            end else if (funct3 == 3'b101) begin
               b_o   = shamt;
               alt   = (funct7 == F7_ALT);
               legal = (funct7 == F7_BASE) || alt;
            end
            ctrl = f3_ctrl(funct3, alt);
         end
         OPC_LUI: begin
            b_o  = upper;
            ctrl = ALU_AUIPC;
         end
         OPC_AUIPC: begin
            a_o  = pc_i;
            b_o  = upper;
            ctrl = ALU_AUIPC;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         a_o  = '0;
         b_o  = '0;
         ctrl = ALU_ADD;
      end
      ctl_o.ctrl    = ctrl;
      ctl_o.cmp_sel = legal && (ctrl == ALU_SLT || ctrl == ALU_SLTU);
      ctl_o.rd      = rd;
      ctl_o.we      = legal && (rd != 5'd0);
      ctl_o.illegal = !legal;
   end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX issue slot: 1-cycle latency, valid/ready both sides, flush kills everything.
// ALU_OP_ISSUE_SKID_EN adds a skid entry so in_ready is registered.
module alu_op_issue import alu_op_pkg::*; #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_instr,
   input  logic [N-1:0] in_pc,
   input  logic [N-1:0] in_rs1,
   input  logic [N-1:0] in_rs2,
   output logic         ex_valid,
   input  logic         ex_ready,
   output logic [N-1:0] ex_a,
   output logic [N-1:0] ex_b,
   output logic [3:0]   ex_ctrl,
   output logic         ex_cmp_sel,
   output logic [4:0]   ex_rd,
   output logic         ex_we,
   output logic         ex_illegal
);

   logic [N-1:0] dec_a;
   logic [N-1:0] dec_b;
   issue_ctl_t   dec_ctl;

   logic         vld_d, vld_q;
   logic [N-1:0] a_d, a_q;
   logic [N-1:0] b_d, b_q;
   issue_ctl_t   ctl_d, ctl_q;
   logic         in_fire;
   logic         out_fire;

   alu_op_decode #(.N(N)) u_decode (
      .instr_i (in_instr),
      .pc_i    (in_pc),
      .rs1_i   (in_rs1),
      .rs2_i   (in_rs2),
      .a_o     (dec_a),
      .b_o     (dec_b),
      .ctl_o   (dec_ctl)
   );

   assign out_fire = vld_q && ex_ready;
   assign in_fire  = in_valid && in_ready && !flush;

`ifdef ALU_OP_ISSUE_SKID_EN
   logic         sk_vld_d, sk_vld_q;
   logic [N-1:0] sk_a_d, sk_a_q;
   logic [N-1:0] sk_b_d, sk_b_q;
   issue_ctl_t   sk_ctl_d, sk_ctl_q;

   // a full skid entry is the only reason to refuse input
   assign in_ready = !sk_vld_q;

   always_comb begin
      vld_d    = vld_q;
      a_d      = a_q;
      b_d      = b_q;
      ctl_d    = ctl_q;
      sk_vld_d = sk_vld_q;
      sk_a_d   = sk_a_q;
      sk_b_d   = sk_b_q;
      sk_ctl_d = sk_ctl_q;
      if (flush) begin
         vld_d    = 1'b0;
         sk_vld_d = 1'b0;
      end else if (sk_vld_q) begin
         if (out_fire) begin
            vld_d    = 1'b1;
            a_d      = sk_a_q;
            b_d      = sk_b_q;
            ctl_d    = sk_ctl_q;
            sk_vld_d = 1'b0;
         end
      end else if (in_fire) begin
         if (!vld_q || out_fire) begin
            vld_d = 1'b1;
            a_d   = dec_a;
            b_d   = dec_b;
            ctl_d = dec_ctl;
         end else begin
            sk_vld_d = 1'b1;
            sk_a_d   = dec_a;
            sk_b_d   = dec_b;
            sk_ctl_d = dec_ctl;
         end
      end else if (out_fire) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sk_vld_q <= 1'b0;
         sk_a_q   <= '0;
         sk_b_q   <= '0;
         sk_ctl_q <= '0;
      end else begin
         sk_vld_q <= sk_vld_d;
         sk_a_q   <= sk_a_d;
         sk_b_q   <= sk_b_d;
         sk_ctl_q <= sk_ctl_d;
      end
   end
`else
   assign in_ready = !vld_q || ex_ready;

   always_comb begin
      vld_d = vld_q;
      a_d   = a_q;
      b_d   = b_q;
      ctl_d = ctl_q;
      if (flush) begin
         vld_d = 1'b0;
      end else if (in_fire) begin
         vld_d = 1'b1;
         a_d   = dec_a;
         b_d   = dec_b;
         ctl_d = dec_ctl;
      end else if (out_fire) begin
         vld_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         ctl_q <= '0;
      end else begin
         vld_q <= vld_d;
         a_q   <= a_d;
         b_q   <= b_d;
         ctl_q <= ctl_d;
      end
   end

   assign ex_valid   = vld_q;
   assign ex_a       = a_q;
   assign ex_b       = b_q;
   assign ex_ctrl    = ctl_q.ctrl;
   assign ex_cmp_sel = ctl_q.cmp_sel;
   assign ex_rd      = ctl_q.rd;
   assign ex_we      = ctl_q.we;
   assign ex_illegal = ctl_q.illegal;

endmodule
